// File: rtl/vme_ader_decoder.sv
// rtl/vme_ader_decoder.sv - CR/CSR ADER registers and two-function VME slave decoder
//
// Purpose:
//   Holds the ADER registers of both functions and the module-enable bit,
//   all programmed over CR/CSR. Every slave access (address + AM) goes
//   through a three-stage pipeline and is decoded against both functions.
//   The result is reported as a one-cycle ack carrying hit, function number
//   and in-window offset.
//
// Ports:
//   clk_sys_i     system clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   csr_we_i      CR/CSR byte write strobe
//   csr_addr_i    CR/CSR byte address (19 bits)
//   csr_data_i    CR/CSR write data
//   csr_data_o    registered read data for csr_addr_i
//   dec_req_i     decode request, one per cycle
//   dec_addr_i    VME address (A24 in [23:0])
//   dec_am_i      VME address modifier
//   dec_ack_o     one-cycle pulse, decode result valid
//   dec_hit_o     access matched an enabled function
//   dec_func_o    matching function number
//   dec_offset_o  in-window offset of the matched function, else 0
//   module_en_o   module enable bit
//   miss_cnt_o    saturating count of acks with hit = 0
module vme_ader_decoder #(
  parameter logic [31:0] G_ADEM_F0 = 32'hFFF00000,
  parameter logic [31:0] G_ADEM_F1 = 32'h00F80000,
  parameter int          G_CNT_W   = 16
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  input  logic               csr_we_i,
  input  logic [18:0]        csr_addr_i,
  input  logic [7:0]         csr_data_i,
  output logic [7:0]         csr_data_o,
  input  logic               dec_req_i,
  input  logic [31:0]        dec_addr_i,
  input  logic [5:0]         dec_am_i,
  output logic               dec_ack_o,
  output logic               dec_hit_o,
  output logic               dec_func_o,
  output logic [31:0]        dec_offset_o,
  output logic               module_en_o,
  output logic [G_CNT_W-1:0] miss_cnt_o
);

  localparam logic [18:0] ADDR_BIT_SET = 19'h7FFFB;
  localparam logic [18:0] ADDR_BIT_CLR = 19'h7FFF7;

  // Only bits [31:8] take part in the address compare.
  localparam logic [31:0] CMP_F0 = G_ADEM_F0 & 32'hFFFFFF00;
  localparam logic [31:0] CMP_F1 = G_ADEM_F1 & 32'hFFFFFF00;

  // An A24 function (no mask bits in the upper byte) ignores the address
  // upper byte completely, so it is also stripped from the offset.
  localparam logic [31:0] KEEP_F0 = (G_ADEM_F0[31:24] == 8'h00) ? 32'h00FFFFFF : 32'hFFFFFFFF;
  localparam logic [31:0] KEEP_F1 = (G_ADEM_F1[31:24] == 8'h00) ? 32'h00FFFFFF : 32'hFFFFFFFF;
  localparam logic [31:0] OFS_F0  = ~G_ADEM_F0 & KEEP_F0;
  localparam logic [31:0] OFS_F1  = ~G_ADEM_F1 & KEEP_F1;

  logic [31:0] ader0;
  logic [31:0] ader1;
  logic        module_en;
  logic [7:0]  csr_rdata;

  logic        s1_valid;
  logic [31:0] s1_addr;
  logic [5:0]  s1_am;
  logic        s2_valid;
  logic [31:0] s2_addr;
  logic [5:0]  s2_am;

  logic        match0;
  logic        match1;

  assign module_en_o = module_en;

  // CSR writes: ADER bytes are big-endian across k, 4 bytes apart.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ader0     <= '0;
      ader1     <= '0;
      module_en <= 1'b0;
    end else if (csr_we_i) begin
      case (csr_addr_i)
        19'h7FF63: ader0[31:24] <= csr_data_i;
        19'h7FF67: ader0[23:16] <= csr_data_i;
        19'h7FF6B: ader0[15:8]  <= csr_data_i;
        19'h7FF6F: ader0[7:0]   <= csr_data_i;
        19'h7FF73: ader1[31:24] <= csr_data_i;
        19'h7FF77: ader1[23:16] <= csr_data_i;
        19'h7FF7B: ader1[15:8]  <= csr_data_i;
        19'h7FF7F: ader1[7:0]   <= csr_data_i;
        ADDR_BIT_SET: if (csr_data_i[4]) module_en <= 1'b1;
        ADDR_BIT_CLR: if (csr_data_i[4]) module_en <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 8'h00;
    case (csr_addr_i)
      19'h7FF63: csr_rdata = ader0[31:24];
      19'h7FF67: csr_rdata = ader0[23:16];
      19'h7FF6B: csr_rdata = ader0[15:8];
      19'h7FF6F: csr_rdata = ader0[7:0];
      19'h7FF73: csr_rdata = ader1[31:24];
      19'h7FF77: csr_rdata = ader1[23:16];
      19'h7FF7B: csr_rdata = ader1[15:8];
      19'h7FF7F: csr_rdata = ader1[7:0];
      ADDR_BIT_SET,
      ADDR_BIT_CLR: csr_rdata = {3'b000, module_en, 4'b0000};
      default: csr_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csr_data_o <= 8'h00;
    end else begin
      csr_data_o <= csr_rdata;
    end
  end

  // Two capture stages ahead of the compare, so that the compare sees the
  // ADER/enable state as it stands after the edge following the request.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_am    <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_am    <= '0;
    end else begin
      s1_valid <= dec_req_i;
      s1_addr  <= dec_addr_i;
      s1_am    <= dec_am_i;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_am    <= s1_am;
    end
  end

  always_comb begin
    match0 = module_en && (s2_am == ader0[7:2]) && (((s2_addr ^ ader0) & CMP_F0) == 32'h0);
    match1 = module_en && (s2_am == ader1[7:2]) && (((s2_addr ^ ader1) & CMP_F1) == 32'h0);
  end

  // Result stage: function 0 takes priority; results hold between acks.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dec_ack_o    <= 1'b0;
      dec_hit_o    <= 1'b0;
      dec_func_o   <= 1'b0;
      dec_offset_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      dec_ack_o <= s2_valid;
      if (s2_valid) begin
        if (match0) begin
          dec_hit_o    <= 1'b1;
          dec_func_o   <= 1'b0;
          dec_offset_o <= s2_addr & OFS_F0;
        end else if (match1) begin
          dec_hit_o    <= 1'b1;
          dec_func_o   <= 1'b1;
          dec_offset_o <= s2_addr & OFS_F1;
        end else begin
          dec_hit_o    <= 1'b0;
          dec_func_o   <= 1'b0;
          dec_offset_o <= '0;
          if (!(&miss_cnt_o)) begin
            miss_cnt_o <= miss_cnt_o + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vme_ader_decoder.sv
// tb/tb_vme_ader_decoder.sv - directed self-checking bench for vme_ader_decoder
module tb_vme_ader_decoder;

  logic        clk_sys_i = 1'b0;
  logic        rst_n_i   = 1'b0;
  logic        csr_we_i  = 1'b0;
  logic [18:0] csr_addr_i = '0;
  logic [7:0]  csr_data_i = '0;
  logic [7:0]  csr_data_o;
  logic        dec_req_i  = 1'b0;
  logic [31:0] dec_addr_i = '0;
  logic [5:0]  dec_am_i   = '0;
  logic        dec_ack_o;
  logic        dec_hit_o;
  logic        dec_func_o;
  logic [31:0] dec_offset_o;
  logic        module_en_o;
  logic [15:0] miss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_miss = 0;

  always #5 clk_sys_i = ~clk_sys_i;

  vme_ader_decoder #(
    .G_ADEM_F0(32'hFFF00000),
    .G_ADEM_F1(32'h00F80000),
    .G_CNT_W  (16)
  ) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_data_i  (csr_data_i),
    .csr_data_o  (csr_data_o),
    .dec_req_i   (dec_req_i),
    .dec_addr_i  (dec_addr_i),
    .dec_am_i    (dec_am_i),
    .dec_ack_o   (dec_ack_o),
    .dec_hit_o   (dec_hit_o),
    .dec_func_o  (dec_func_o),
    .dec_offset_o(dec_offset_o),
    .module_en_o (module_en_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic csr_wr(input logic [18:0] a, input logic [7:0] d);
    csr_we_i   = 1'b1;
    csr_addr_i = a;
    csr_data_i = d;
    tick();
    csr_we_i = 1'b0;
  endtask

  // Issue one request at E0 and return just after E2, where the ack is due.
  task automatic req_wait(input logic [31:0] a, input logic [5:0] am);
    dec_req_i  = 1'b1;
    dec_addr_i = a;
    dec_am_i   = am;
    tick();
    dec_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #12;
    n_checks++; if (dec_ack_o !== 1'b0) $display("FAIL reset_ack got %b exp 0", dec_ack_o); else n_pass++;
    n_checks++; if ({dec_hit_o, dec_func_o, module_en_o} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {dec_hit_o, dec_func_o, module_en_o}); else n_pass++;
    n_checks++; if (dec_offset_o !== 32'h0) $display("FAIL reset_offset got %h exp 0", dec_offset_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 16'h0) $display("FAIL reset_miss got %h exp 0", miss_cnt_o); else n_pass++;
    n_checks++; if (csr_data_o !== 8'h00) $display("FAIL reset_csr got %h exp 00", csr_data_o); else n_pass++;
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_disabled_miss();
    req_wait(32'h80000000, 6'h09);
    exp_miss++;
    n_checks++; if (dec_ack_o !== 1'b1) $display("FAIL dis_ack got %b exp 1", dec_ack_o); else n_pass++;
    n_checks++; if (dec_hit_o !== 1'b0) $display("FAIL dis_hit got %b exp 0", dec_hit_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 16'(exp_miss)) $display("FAIL dis_miss got %0d exp %0d", miss_cnt_o, exp_miss); else n_pass++;
    tick();
    n_checks++; if (dec_ack_o !== 1'b0) $display("FAIL dis_ack_pulse got %b exp 0", dec_ack_o); else n_pass++;
  endtask

  task automatic test_program();
    csr_wr(19'h7FF63, 8'h80);
    csr_wr(19'h7FF67, 8'h00);
    csr_wr(19'h7FF6B, 8'h00);
    csr_wr(19'h7FF6F, 8'h24);
    csr_wr(19'h7FF73, 8'h00);
    csr_wr(19'h7FF77, 8'hC0);
    csr_wr(19'h7FF7B, 8'h00);
    csr_wr(19'h7FF7F, 8'hE4);
    csr_wr(19'h7FFFB, 8'h10);
    n_checks++; if (module_en_o !== 1'b1) $display("FAIL prog_en got %b exp 1", module_en_o); else n_pass++;
  endtask

  task automatic test_func0_hit();
    req_wait(32'h80000010, 6'h09);
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o} !== 3'b110) $display("FAIL f0_flags got %b exp 110", {dec_ack_o, dec_hit_o, dec_func_o}); else n_pass++;
    n_checks++; if (dec_offset_o !== 32'h10) $display("FAIL f0_offset got %h exp 00000010", dec_offset_o); else n_pass++;
    tick();
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_offset_o} !== {2'b01, 32'h10}) $display("FAIL f0_hold got %b/%b/%h exp 0/1/00000010", dec_ack_o, dec_hit_o, dec_offset_o); else n_pass++;
  endtask

  task automatic test_func1_hit();
    req_wait(32'h00C00004, 6'h39);
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o} !== 3'b111) $display("FAIL f1_flags got %b exp 111", {dec_ack_o, dec_hit_o, dec_func_o}); else n_pass++;
    n_checks++; if (dec_offset_o !== 32'h4) $display("FAIL f1_offset got %h exp 00000004", dec_offset_o); else n_pass++;
    req_wait(32'hFFC00004, 6'h39);
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o} !== 3'b111) $display("FAIL f1_upper_flags got %b exp 111", {dec_ack_o, dec_hit_o, dec_func_o}); else n_pass++;
    n_checks++; if (dec_offset_o !== 32'h4) $display("FAIL f1_upper_offset got %h exp 00000004", dec_offset_o); else n_pass++;
  endtask

  task automatic test_am_mismatch();
    req_wait(32'h80000000, 6'h39);
    exp_miss++;
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o} !== 3'b100) $display("FAIL am_flags got %b exp 100", {dec_ack_o, dec_hit_o, dec_func_o}); else n_pass++;
    n_checks++; if (dec_offset_o !== 32'h0) $display("FAIL am_offset got %h exp 0", dec_offset_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 16'(exp_miss)) $display("FAIL am_miss got %0d exp %0d", miss_cnt_o, exp_miss); else n_pass++;
  endtask

  task automatic test_back_to_back();
    dec_req_i = 1'b1;
    dec_addr_i = 32'h80000010; dec_am_i = 6'h09; tick();
    dec_addr_i = 32'h00C00004; dec_am_i = 6'h39; tick();
    dec_addr_i = 32'h80000000; dec_am_i = 6'h39; tick();
    dec_req_i = 1'b0;
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o} !== {3'b110, 32'h10}) $display("FAIL b2b_1 got %b%b%b/%h exp 110/00000010", dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o); else n_pass++;
    tick();
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o} !== {3'b111, 32'h4}) $display("FAIL b2b_2 got %b%b%b/%h exp 111/00000004", dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o); else n_pass++;
    tick();
    exp_miss++;
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o} !== {3'b100, 32'h0}) $display("FAIL b2b_3 got %b%b%b/%h exp 100/00000000", dec_ack_o, dec_hit_o, dec_func_o, dec_offset_o); else n_pass++;
    tick();
    n_checks++; if (dec_ack_o !== 1'b0) $display("FAIL b2b_end got %b exp 0", dec_ack_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 16'(exp_miss)) $display("FAIL b2b_miss got %0d exp %0d", miss_cnt_o, exp_miss); else n_pass++;
  endtask

  task automatic test_csr_timing();
    // Write lands at E1: the request must see ADER0 = 0x40000024.
    dec_req_i = 1'b1; dec_addr_i = 32'h40000000; dec_am_i = 6'h09;
    tick();
    dec_req_i = 1'b0;
    csr_we_i = 1'b1; csr_addr_i = 19'h7FF63; csr_data_i = 8'h40;
    tick();
    csr_we_i = 1'b0;
    tick();
    n_checks++; if ({dec_ack_o, dec_hit_o, dec_func_o} !== 3'b110) $display("FAIL wr_e1 got %b exp 110", {dec_ack_o, dec_hit_o, dec_func_o}); else n_pass++;
    csr_wr(19'h7FF63, 8'h80);
    // Write lands at E2: too late for this request.
    dec_req_i = 1'b1;
    tick();
    dec_req_i = 1'b0;
    tick();
    csr_we_i = 1'b1; csr_addr_i = 19'h7FF63; csr_data_i = 8'h40;
    tick();
    csr_we_i = 1'b0;
    exp_miss++;
    n_checks++; if ({dec_ack_o, dec_hit_o} !== 2'b10) $display("FAIL wr_e2 got %b exp 10", {dec_ack_o, dec_hit_o}); else n_pass++;
    csr_wr(19'h7FF63, 8'h80);
    n_checks++; if (miss_cnt_o !== 16'(exp_miss)) $display("FAIL wr_miss got %0d exp %0d", miss_cnt_o, exp_miss); else n_pass++;
  endtask

  task automatic test_readback();
    csr_addr_i = 19'h7FF6F; tick();
    n_checks++; if (csr_data_o !== 8'h24) $display("FAIL rd_ader0_b3 got %h exp 24", csr_data_o); else n_pass++;
    csr_addr_i = 19'h7FF77; tick();
    n_checks++; if (csr_data_o !== 8'hC0) $display("FAIL rd_ader1_b1 got %h exp c0", csr_data_o); else n_pass++;
    csr_addr_i = 19'h7FFFB; tick();
    n_checks++; if (csr_data_o !== 8'h10) $display("FAIL rd_bitset got %h exp 10", csr_data_o); else n_pass++;
    csr_addr_i = 19'h7FF60; tick();
    n_checks++; if (csr_data_o !== 8'h00) $display("FAIL rd_unmapped got %h exp 00", csr_data_o); else n_pass++;
    csr_wr(19'h7FFF7, 8'hEF);
    n_checks++; if (module_en_o !== 1'b1) $display("FAIL clr_bit4_0 got %b exp 1", module_en_o); else n_pass++;
    csr_wr(19'h7FFF7, 8'h10);
    n_checks++; if (module_en_o !== 1'b0) $display("FAIL clr got %b exp 0", module_en_o); else n_pass++;
    csr_addr_i = 19'h7FFF7; tick();
    n_checks++; if (csr_data_o !== 8'h00) $display("FAIL rd_bitclr got %h exp 00", csr_data_o); else n_pass++;
    csr_wr(19'h7FFFB, 8'h10);
    req_wait(32'h80000000, 6'h09);
    n_checks++; if ({dec_ack_o, dec_hit_o} !== 2'b11) $display("FAIL reenable_hit got %b exp 11", {dec_ack_o, dec_hit_o}); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int acks;
    dec_req_i = 1'b1; dec_addr_i = 32'h80000010; dec_am_i = 6'h09;
    tick();
    dec_req_i = 1'b0;
    tick();
    rst_n_i = 1'b0;
    #1;
    n_checks++; if ({dec_ack_o, dec_hit_o, module_en_o} !== 3'b000) $display("FAIL rst_fly_flags got %b exp 000", {dec_ack_o, dec_hit_o, module_en_o}); else n_pass++;
    n_checks++; if ({miss_cnt_o, dec_offset_o} !== 48'h0) $display("FAIL rst_fly_cnt_ofs got %h/%h exp 0/0", miss_cnt_o, dec_offset_o); else n_pass++;
    tick();
    rst_n_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dec_ack_o === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) $display("FAIL rst_fly_noack got %0d acks exp 0", acks); else n_pass++;
    exp_miss = 0;
  endtask

  task automatic test_saturation();
    dec_req_i = 1'b1; dec_addr_i = 32'h0; dec_am_i = 6'h00;
    for (int i = 0; i < 65539; i++) tick();
    dec_req_i = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (miss_cnt_o !== 16'hFFFF) $display("FAIL sat got %h exp ffff", miss_cnt_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_disabled_miss();
    test_program();
    test_func0_hit();
    test_func1_hit();
    test_am_mismatch();
    test_back_to_back();
    test_csr_timing();
    test_readback();
    test_reset_inflight();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
